// File: rtl/somador_subtrator_serial.sv
// Digit-serial adder/subtractor: DIGITO bits per cycle, LSB first, valid/ready on both sides.
// Optional macro SATURACAO_EN clamps the result to the signed extreme on overflow.
module somador_subtrator_serial #(
  parameter int LARGURA = 8,
  parameter int DIGITO  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  output logic               pronto,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic               op,
  output logic [LARGURA:0]   s,
  output logic               valido,
  input  logic               aceito,
  output logic               zero,
  output logic               ovf
);

  localparam int N  = LARGURA / DIGITO;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    OCIOSO,
    CALCULA,
    CONCLUIDO
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   a_q, a_d;
  logic [LARGURA-1:0]   b_q, b_d;
  logic                 op_q, op_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LARGURA:0]     s_q, s_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;

  logic [DIGITO:0]         digito_soma;
  logic [LARGURA+DIGITO-1:0] desloc;
  logic                    carry_msb_in;
  logic                    ovf_fin;

  // One digit of the ripple: the low DIGITO bits of the shifting operands plus the carry.
  assign digito_soma  = {1'b0, a_q[DIGITO-1:0]} + {1'b0, b_q[DIGITO-1:0]}
                      + {{DIGITO{1'b0}}, carry_q};
  assign desloc       = {digito_soma[DIGITO-1:0], s_q[LARGURA-1:0]};
  // On the last digit, the carry into the MSB is recovered from the MSB sum bit.
  assign carry_msb_in = a_q[DIGITO-1] ^ b_q[DIGITO-1] ^ digito_soma[DIGITO-1];
  assign ovf_fin      = carry_msb_in ^ digito_soma[DIGITO];

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latches).
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          a_d      = a;
          b_d      = b ^ {LARGURA{op}};
          op_d     = op;
          carry_d  = op;
          cnt_d    = '0;
          estado_d = CALCULA;
        end
      end

      CALCULA: begin
        a_d                = a_q >> DIGITO;
        b_d                = b_q >> DIGITO;
        carry_d            = digito_soma[DIGITO];
        s_d[LARGURA-1:0]   = desloc[LARGURA+DIGITO-1:DIGITO];
        cnt_d              = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d       = '0;
          estado_d    = CONCLUIDO;
          s_d[LARGURA] = digito_soma[DIGITO] ^ op_q;
          ovf_d       = ovf_fin;
`ifdef SATURACAO_EN
          // a_q[DIGITO-1] is the original sign of a after N-1 shifts.
          if (ovf_fin) begin
            s_d[LARGURA-1:0] = a_q[DIGITO-1] ? {1'b1, {(LARGURA-1){1'b0}}}
                                             : {1'b0, {(LARGURA-1){1'b1}}};
            s_d[LARGURA]     = s_d[LARGURA-1];
          end
`endif
          zero_d = (s_d[LARGURA-1:0] == '0);
        end
      end

      CONCLUIDO: begin
        if (aceito) estado_d = OCIOSO;
      end

      default: estado_d = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop, datapath included,
  // is cleared by the async reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= OCIOSO;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pronto = (estado_q == OCIOSO) && !rst;
  assign valido = (estado_q == CONCLUIDO);
  assign s      = s_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Self-checking bench for somador_subtrator_serial: directed cases, random ops against an
// arithmetic reference model, backpressure, mid-operation reset and a 16/4 instance.
module tb_somador_subtrator_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio, op, aceito;
  logic [7:0]  a, b;
  logic        pronto, valido, zero, ovf;
  logic [8:0]  s;

  logic        inicio16, op16, aceito16;
  logic [15:0] a16, b16;
  logic        pronto16, valido16, zero16, ovf16;
  logic [16:0] s16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  somador_subtrator_serial #(.LARGURA(8), .DIGITO(2)) u_dut (
    .clk(clk), .rst(rst), .inicio(inicio), .pronto(pronto), .a(a), .b(b), .op(op),
    .s(s), .valido(valido), .aceito(aceito), .zero(zero), .ovf(ovf)
  );

  somador_subtrator_serial #(.LARGURA(16), .DIGITO(4)) u_dut16 (
    .clk(clk), .rst(rst), .inicio(inicio16), .pronto(pronto16), .a(a16), .b(b16), .op(op16),
    .s(s16), .valido(valido16), .aceito(aceito16), .zero(zero16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input longint unsigned ta, input longint unsigned tb_,
                                input bit top, output longint unsigned es,
                                output bit ez, output bit eo);
    longint unsigned m_res = (64'd1 << (w + 1)) - 1;
    longint unsigned m_low = (64'd1 << w) - 1;
    longint sa, sb, r;
    sa = ta[w-1] ? longint'(ta) - (longint'(1) << w) : longint'(ta);
    sb = tb_[w-1] ? longint'(tb_) - (longint'(1) << w) : longint'(tb_);
    r  = top ? sa - sb : sa + sb;
    eo = (r > (longint'(1) << (w - 1)) - 1) || (r < -(longint'(1) << (w - 1)));
    es = top ? (ta - tb_) & m_res : (ta + tb_) & m_res;
`ifdef SATURACAO_EN
    if (eo) begin
      es = ta[w-1] ? (64'd1 << (w - 1)) : (64'd1 << (w - 1)) - 1;
      es = es | (es[w-1] ? (64'd1 << w) : 64'd0);
    end
`endif
    ez = ((es & m_low) == 0);
  endfunction

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic top,
                       input int hold);
    longint unsigned es;
    bit ez, eo;
    int lat = 0;
    model(8, ta, tb_, top, es, ez, eo);
    while (!pronto && lat < 50) begin @(posedge clk); #1; lat++; end
    check("pronto_antes", pronto, 1);
    @(negedge clk);
    a = ta; b = tb_; op = top; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
    check("pronto_calc", pronto, 0);
    lat = 0;
    while (!valido && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latencia", lat, 4);
    check("s", s, es);
    check("zero", zero, ez);
    check("ovf", ovf, eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_s", s, es);
      check("hold_valido", valido, 1);
      check("hold_pronto", pronto, 0);
    end
    @(negedge clk); aceito = 1'b1;
    @(posedge clk); #1; aceito = 1'b0;
    check("valido_baixo", valido, 0);
    check("pronto_volta", pronto, 1);
  endtask

  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb_, input logic top);
    longint unsigned es;
    bit ez, eo;
    int lat = 0;
    model(16, ta, tb_, top, es, ez, eo);
    while (!pronto16 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("pronto16", pronto16, 1);
    @(negedge clk);
    a16 = ta; b16 = tb_; op16 = top; inicio16 = 1'b1;
    @(posedge clk); #1; inicio16 = 1'b0;
    lat = 0;
    while (!valido16 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latencia16", lat, 4);
    check("s16", s16, es);
    check("zero16", zero16, ez);
    check("ovf16", ovf16, eo);
    @(negedge clk); aceito16 = 1'b1;
    @(posedge clk); #1; aceito16 = 1'b0;
    check("valido16_baixo", valido16, 0);
  endtask

  initial begin
    rst = 1'b1; inicio = 0; op = 0; aceito = 0; a = 0; b = 0;
    inicio16 = 0; op16 = 0; aceito16 = 0; a16 = 0; b16 = 0;
    #3;
    check("rst_pronto", pronto, 0);
    check("rst_s", s, 0);
    check("rst_valido", valido, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("pos_rst_pronto", pronto, 1);

    do_op(8'd5,   8'd5,   1'b0, 0);
    do_op(8'd5,   8'd10,  1'b1, 0);
    do_op(8'd255, 8'd255, 1'b0, 0);
    do_op(8'd255, 8'd255, 1'b1, 0);
    do_op(8'd50,  8'd100, 1'b1, 0);
    do_op(8'd100, 8'd50,  1'b0, 0);
    do_op(8'd128, 8'd1,   1'b1, 0);
    do_op(8'd200, 8'd100, 1'b1, 10);

    // Abort in the second compute cycle.
    @(negedge clk);
    a = 8'd100; b = 8'd50; op = 1'b0; inicio = 1'b1;
    @(posedge clk); #1; inicio = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_s", s, 0);
    check("abort_valido", valido, 0);
    check("abort_zero", zero, 0);
    check("abort_ovf", ovf, 0);
    check("abort_pronto", pronto, 0);
    @(negedge clk); rst = 1'b0;
    do_op(8'd10, 8'd5, 1'b1, 0);

    for (int i = 0; i < 40; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), (i % 8 == 0) ? 2 : 0);

    do_op16(16'hFFFF, 16'h0001, 1'b0);
    do_op16(16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 10; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
